// File: rtl/lt24_touch_sampler.sv
// lt24_touch_sampler
//   Touch-panel front end for the LT24 module. The block drives an
//   ADS7843-class touch ADC over its 4-wire serial bus. Each press becomes an
//   X conversion (command 8'hD0) followed by a Y conversion (command 8'h90).
//   The two 12-bit results are scaled to screen space, and the coordinates go
//   out with a one-cycle valid strobe.
//
//   Optional feature: define TOUCH_AVG_EN to convert each axis four times
//   back-to-back and average the samples before scaling.
//
// Parameters
//   CLK_DIV     clk cycles per DCLK half-period (2..255)
//   SAMPLE_GAP  idle clk cycles after a frame before the next penirq check
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   adc_penirq_n  pen-down request from the ADC (async, active-low)
//   adc_dout      ADC serial data (async)
//   adc_busy      ADC busy flag, unused because the frame timing is fixed
//   adc_cs_n      ADC chip select, active-low
//   adc_dclk      ADC serial clock
//   adc_din       ADC serial command data
//   touch_x       screen X coordinate, 0..239
//   touch_y       screen Y coordinate, 0..319
//   touch_valid   one-cycle strobe; touch_x/touch_y change on this cycle
//   touch_down    high from the first strobe of a press until release is seen
module lt24_touch_sampler #(
  parameter int CLK_DIV    = 25,
  parameter int SAMPLE_GAP = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_penirq_n,
  input  logic        adc_dout,
  input  logic        adc_busy,
  output logic        adc_cs_n,
  output logic        adc_dclk,
  output logic        adc_din,
  output logic [10:0] touch_x,
  output logic [10:0] touch_y,
  output logic        touch_valid,
  output logic        touch_down
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE, S_GAP
  } state_e;

  localparam logic [19:0] DIV_LAST = 20'(CLK_DIV - 1);
  localparam logic [19:0] GAP_LAST = 20'(SAMPLE_GAP - 1);
  localparam logic [7:0]  CMD_X    = 8'hD0;
  localparam logic [7:0]  CMD_Y    = 8'h90;

  state_e      state_q, state_d;
  logic        pen_meta_q, pen_q, dout_meta_q, dout_q;
  logic [19:0] cnt_q, cnt_d;        // shared phase / gap counter
  logic [4:0]  bit_q, bit_d;        // DCLK period index 0..23
  logic        axis_y_q, axis_y_d;
  logic [11:0] shreg_q, shreg_d;
  logic [11:0] raw_x_q, raw_x_d;
  logic        cs_n_q, cs_n_d, dclk_q, dclk_d, din_q, din_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        valid_q, valid_d, down_q, down_d;

  logic [7:0]  cmd;
  logic [2:0]  din_idx;
  logic [11:0] raw;                 // finished axis result
  logic        last_rep;            // this conversion completes its axis
  logic [19:0] prod_x;
  logic [20:0] prod_y;
  logic        busy_unused;

  assign busy_unused = adc_busy;

`ifdef TOUCH_AVG_EN
  logic [13:0] acc_q, acc_d, acc_sum;
  logic [1:0]  rep_q, rep_d;

  assign acc_sum  = acc_q + {2'b00, shreg_q};
  assign raw      = acc_sum[13:2];
  assign last_rep = (rep_q == 2'd3);
`else
  assign raw      = shreg_q;
  assign last_rep = 1'b1;
`endif

  // Full-width products, truncated by taking the upper bits (no rounding).
  assign prod_x  = 20'(raw_x_q) * 20'd240;
  assign prod_y  = 21'(raw) * 21'd320;
  assign cmd     = axis_y_q ? CMD_Y : CMD_X;
  assign din_idx = 3'd6 - bit_q[2:0];

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    axis_y_d = axis_y_q;
    shreg_d  = shreg_q;
    raw_x_d  = raw_x_q;
    cs_n_d   = cs_n_q;
    dclk_d   = dclk_q;
    din_d    = din_q;
    x_d      = x_q;
    y_d      = y_q;
    valid_d  = 1'b0;
    down_d   = down_q;
`ifdef TOUCH_AVG_EN
    acc_d    = acc_q;
    rep_d    = rep_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!pen_q) begin
          state_d  = S_SETUP;
          axis_y_d = 1'b0;
          cs_n_d   = 1'b0;
          din_d    = CMD_X[7];
          cnt_d    = '0;
`ifdef TOUCH_AVG_EN
          acc_d    = '0;
          rep_d    = '0;
`endif
        end else begin
          down_d = 1'b0;
        end
      end
      S_SETUP: begin
        cnt_d = cnt_q + 20'd1;
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 20'd1;
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!dclk_q) begin
            // Rising edge number bit_q+1; edges 10..21 carry result bits 11..0.
            dclk_d = 1'b1;
            if (bit_q >= 5'd9 && bit_q <= 5'd20)
              shreg_d = {shreg_q[10:0], dout_q};
          end else begin
            dclk_d = 1'b0;
            if (bit_q == 5'd23) begin
              state_d = S_HOLD;
              cs_n_d  = 1'b1;
              din_d   = 1'b0;
            end else begin
              bit_d = bit_q + 5'd1;
              // Next command bit goes out on the falling edge; zero once all 8 are sent.
              din_d = (bit_q < 5'd7) ? cmd[din_idx] : 1'b0;
            end
          end
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q + 20'd1;
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!last_rep) begin
            state_d = S_SETUP;
            cs_n_d  = 1'b0;
            din_d   = cmd[7];
`ifdef TOUCH_AVG_EN
            acc_d   = acc_sum;
            rep_d   = rep_q + 2'd1;
`endif
          end else if (!axis_y_q) begin
            raw_x_d  = raw;
            axis_y_d = 1'b1;
            state_d  = S_SETUP;
            cs_n_d   = 1'b0;
            din_d    = CMD_Y[7];
`ifdef TOUCH_AVG_EN
            acc_d    = '0;
            rep_d    = '0;
`endif
          end else begin
            // Outputs are registered, so the strobe is visible during DONE.
            state_d = S_DONE;
            x_d     = {3'b000, prod_x[19:12]};
            y_d     = {2'b00, prod_y[20:12]};
            valid_d = 1'b1;
            down_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: begin
        cnt_d = cnt_q + 20'd1;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pen_meta_q  <= 1'b1;
      pen_q       <= 1'b1;
      dout_meta_q <= 1'b0;
      dout_q      <= 1'b0;
      cnt_q       <= '0;
      bit_q       <= '0;
      axis_y_q    <= 1'b0;
      shreg_q     <= '0;
      raw_x_q     <= '0;
      cs_n_q      <= 1'b1;
      dclk_q      <= 1'b0;
      din_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      valid_q     <= 1'b0;
      down_q      <= 1'b0;
`ifdef TOUCH_AVG_EN
      acc_q       <= '0;
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pen_meta_q  <= adc_penirq_n;
      pen_q       <= pen_meta_q;
      dout_meta_q <= adc_dout;
      dout_q      <= dout_meta_q;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      axis_y_q    <= axis_y_d;
      shreg_q     <= shreg_d;
      raw_x_q     <= raw_x_d;
      cs_n_q      <= cs_n_d;
      dclk_q      <= dclk_d;
      din_q       <= din_d;
      x_q         <= x_d;
      y_q         <= y_d;
      valid_q     <= valid_d;
      down_q      <= down_d;
`ifdef TOUCH_AVG_EN
      acc_q       <= acc_d;
      rep_q       <= rep_d;
`endif
    end
  end

  assign adc_cs_n    = cs_n_q;
  assign adc_dclk    = dclk_q;
  assign adc_din     = din_q;
  assign touch_x     = x_q;
  assign touch_y     = y_q;
  assign touch_valid = valid_q;
  assign touch_down  = down_q;

endmodule

// File: doc/lt24_touch_sampler.md
# lt24_touch_sampler

Hardware touch-panel front end for the LT24 module. It drives the ADS7843-class touch ADC over its 4-wire serial bus, converts each press into screen-space X/Y coordinates and hands them to the LT24 frame-refresh stage as a one-cycle valid strobe. With this block in place, the CPU no longer bit-bangs the ADC to move the on-screen character.

## Interface
Parameters:
- CLK_DIV, 25: clk cycles per DCLK half-period. Range 2..255. DCLK frequency is clk/(2*CLK_DIV).
- SAMPLE_GAP, 50000: idle clk cycles between the end of one measurement frame and the next penirq check. Range 1..2^20-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- adc_penirq_n  in  1  pen-down interrupt from the ADC, asynchronous, active-low.
- adc_dout  in  1  ADC serial data out, asynchronous.
- adc_busy  in  1  ADC busy. Ignored; the frame timing is fixed.
- adc_cs_n  out  1  ADC chip select, active-low.
- adc_dclk  out  1  ADC serial clock.
- adc_din  out  1  ADC serial data in.
- touch_x  out  11  screen X coordinate, 0..239.
- touch_y  out  11  screen Y coordinate, 0..319.
- touch_valid  out  1  one-cycle strobe; touch_x and touch_y are updated on the same cycle.
- touch_down  out  1  level; 1 from the first valid strobe of a press until release is detected.

## Operation
- adc_penirq_n and adc_dout each pass through a 2-flop synchronizer. All decisions use the synchronized copies.
- State machine:
  - IDLE: if penirq is low, latch axis=X, go to SETUP. Otherwise clear touch_down and stay in IDLE.
  - SETUP: cs_n=0, dclk=0, din=cmd[7]. Wait CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 24 DCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high. Rising edges are numbered 1..24.
    - din presents command bits 7..0 MSB-first ahead of edges 1..8. din changes only on the cycle dclk goes low, and is 0 after edge 8.
    - dout is sampled on the cycle dclk rises at edges 10..21, giving result bits 11..0.
  - HOLD: dclk=0, cs_n=1 for CLK_DIV cycles. Then:
    - after an X conversion, go to SETUP with axis=Y;
    - after a Y conversion, go to DONE.
  - DONE: one cycle. Update touch_x and touch_y, pulse touch_valid, set touch_down=1, go to GAP.
  - GAP: count SAMPLE_GAP cycles, then go to IDLE.
- Commands (12-bit, differential, power-down between conversions): X = 8'hD0, Y = 8'h90.
- Scaling, unsigned with a full-width product, truncated and never rounded:
  - touch_x = (raw_x * 240) >> 12, using a 20-bit product.
  - touch_y = (raw_y * 320) >> 12, using a 21-bit product.
  - raw 12'hFFF maps to 239 and 319.
- penirq is not examined during SETUP, SHIFT, HOLD or DONE, because the ADC disturbs it while converting. A release during a frame still completes the frame and strobes valid. The release is seen at the next IDLE check.

## Timing
- Reset values: adc_cs_n=1, adc_dclk=0, adc_din=0, touch_x=0, touch_y=0, touch_valid=0, touch_down=0. State is IDLE and all counters are 0.
- Reset asserted mid-frame takes effect on the next clk edge. cs_n rises immediately, no partial result is written and no strobe is produced.
- One conversion lasts exactly 50*CLK_DIV cycles, from cs_n low through the end of HOLD.
- Latency from an adc_penirq_n falling edge, with the block in IDLE, to touch_valid:
  - 2 synchronizer cycles + 1 IDLE cycle + 100*CLK_DIV cycles.
  - With TOUCH_AVG_EN: 2 + 1 + 400*CLK_DIV cycles.
- Repeat strobes while held: every 100*CLK_DIV + 1 + SAMPLE_GAP + 1 cycles (400*CLK_DIV with averaging).
- touch_down clears on the IDLE cycle that finds penirq high.
- touch_valid is never asserted for two consecutive cycles.

## Configuration
- TOUCH_AVG_EN defined:
  - Each axis is converted 4 times back-to-back (X,X,X,X then Y,Y,Y,Y).
  - The samples accumulate in a 14-bit sum, and raw = sum >> 2 before scaling.
  - Frame length is 8 conversions.
- TOUCH_AVG_EN undefined: one conversion per axis. The accumulator and its counter are not built.

## Test plan
- CLK_DIV=4, SAMPLE_GAP=16. ADC model returns X=12'h800, Y=12'h400. Hold adc_penirq_n low from cycle 10 → din shows D0 then 90; touch_valid pulses at cycle 10+403; touch_x=120, touch_y=80; touch_down=1.
- ADC model returns 12'hFFF on both axes → touch_x=239, touch_y=319. Returns 12'h000 → touch_x=0, touch_y=0.
- Keep the press held → second touch_valid exactly 418 cycles after the first. Release during the second frame → that frame still strobes; touch_down=0 on the IDLE check that follows.
- Assert rst at edge 15 of the Y conversion → adc_cs_n=1 and adc_dclk=0 next cycle; no strobe; outputs keep their reset values.
- With TOUCH_AVG_EN, model returns X samples 100,102,104,106 (sum 412, raw 103) → touch_x=(103*240)>>12=6. Latency is 1603 cycles.
- No press for 10000 cycles → adc_cs_n stays 1, adc_dclk toggles never, touch_valid never asserts.
